// File: rtl/maxnet_controller_if.sv
// Control/status bundle between the Maxnet sequencer and its datapath/top-level handshake.
// master = sequencer side, slave = datapath + start/done requester side.
interface maxnet_controller_if;
    logic       start;
    logic       plu_done;
    logic       finish;
    logic       rst_plu;
    logic       eps_reg_we;
    logic       we_prim;
    logic       we_a_reg;
    logic       mux_sel;
    logic       start_plu;
    logic       busy;
    logic       done;
    logic       converged;
    logic       timeout;
    logic       plu_err;
    logic [7:0] iter_count;

    modport master (
        input  start, plu_done, finish,
        output rst_plu, eps_reg_we, we_prim, we_a_reg, mux_sel, start_plu,
        output busy, done, converged, timeout, plu_err, iter_count
    );

    modport slave (
        output start, plu_done, finish,
        input  rst_plu, eps_reg_we, we_prim, we_a_reg, mux_sel, start_plu,
        input  busy, done, converged, timeout, plu_err, iter_count
    );
endinterface

// File: rtl/maxnet_controller.sv
// Maxnet sequencer: LOAD, then START/WAIT/UPDATE/CHECK rounds until finish, MAX_ITER or a WAIT_LIMIT abort.
// Latency 1 + N*(L+3) + 1 cycles start-to-done; start is accepted only in IDLE and never queued.
module maxnet_controller #(
    parameter int MAX_ITER   = 16,
    parameter int WAIT_LIMIT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    maxnet_controller_if.master  ctl
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_UPDATE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [7:0] MAX_ITER_C = 8'(MAX_ITER);
    localparam logic [7:0] WAIT_LIM_C = 8'(WAIT_LIMIT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] iter_q, iter_d;
    logic       conv_q, conv_d;
    logic       tmo_q, tmo_d;
    logic       err_q, err_d;

    logic       rst_plu, eps_reg_we, we_prim, we_a_reg, mux_sel, start_plu, busy, done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 8'd0;
            iter_q     <= 8'd0;
            conv_q     <= 1'b0;
            tmo_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            iter_q     <= iter_d;
            conv_q     <= conv_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
        end
    end

    // Next-state and sticky status updates.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        iter_d     = iter_q;
        conv_d     = conv_q;
        tmo_d      = tmo_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (ctl.start) begin
                    conv_d  = 1'b0;
                    tmo_d   = 1'b0;
                    err_d   = 1'b0;
                    iter_d  = 8'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_START;
            end
            S_START: begin
                wait_cnt_d = 8'd0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // wait_cnt_d is the number of WAIT cycles spent this round, including this one.
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (ctl.plu_done) begin
                    state_d = S_UPDATE;
                end else if (wait_cnt_d == WAIT_LIM_C) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_UPDATE: begin
                iter_d  = iter_q + 8'd1;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (ctl.finish) begin
                    conv_d  = 1'b1;
                    state_d = S_DONE;
                end else if (iter_q == MAX_ITER_C) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_START;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore control decode.
    always_comb begin
        rst_plu    = 1'b0;
        eps_reg_we = 1'b0;
        we_prim    = 1'b0;
        we_a_reg   = 1'b0;
        mux_sel    = 1'b0;
        start_plu  = 1'b0;
        busy       = (state_q != S_IDLE);
        done       = 1'b0;

        case (state_q)
            S_LOAD: begin
                eps_reg_we = 1'b1;
                we_prim    = 1'b1;
                we_a_reg   = 1'b1;
                rst_plu    = 1'b1;
            end
            S_START: begin
                start_plu = 1'b1;
            end
            S_UPDATE: begin
                mux_sel  = 1'b1;
                we_a_reg = 1'b1;
            end
            S_CHECK: begin
                rst_plu = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign ctl.rst_plu    = rst_plu;
    assign ctl.eps_reg_we = eps_reg_we;
    assign ctl.we_prim    = we_prim;
    assign ctl.we_a_reg   = we_a_reg;
    assign ctl.mux_sel    = mux_sel;
    assign ctl.start_plu  = start_plu;
    assign ctl.busy       = busy;
    assign ctl.done       = done;
    assign ctl.converged  = conv_q;
    assign ctl.timeout    = tmo_q;
    assign ctl.plu_err    = err_q;
    assign ctl.iter_count = iter_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller: per-cycle expected control trace and end-of-run results are queued
// when a run is launched and popped as the DUT steps through it.
module tb_maxnet_controller;

    localparam int MAX_ITER   = 4;
    localparam int WAIT_LIMIT = 5;

    // {rst_plu, eps_reg_we, we_prim, we_a_reg, mux_sel, start_plu, busy, done}
    localparam logic [7:0] C_IDLE  = 8'b0000_0000;
    localparam logic [7:0] C_LOAD  = 8'b1111_0010;
    localparam logic [7:0] C_START = 8'b0000_0110;
    localparam logic [7:0] C_WAIT  = 8'b0000_0010;
    localparam logic [7:0] C_UPD   = 8'b0001_1010;
    localparam logic [7:0] C_CHK   = 8'b1000_0010;
    localparam logic [7:0] C_DONE  = 8'b0000_0011;

    typedef struct {
        logic [7:0] ctl;
        logic [2:0] fl;   // {converged, timeout, plu_err}
        logic [7:0] it;
        logic       pd;
        logic       care_pd;
        logic       fn;
        logic       care_fn;
        logic       st;
        logic       rs;
    } step_t;

    typedef struct packed {
        logic [2:0] fl;
        logic [7:0] it;
    } res_t;

    step_t exp_q[$];
    res_t  res_q[$];
    int    total = 0;
    int    bad   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    maxnet_controller_if ifc ();

    maxnet_controller #(
        .MAX_ITER  (MAX_ITER),
        .WAIT_LIMIT(WAIT_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ctl(ifc)
    );

    always #5 clk = ~clk;

    function automatic step_t mk(input logic [7:0] c, input logic [2:0] f, input logic [7:0] i);
        step_t s;
        s.ctl = c; s.fl = f; s.it = i;
        s.pd = 1'b0; s.care_pd = 1'b0; s.fn = 1'b0; s.care_fn = 1'b0;
        s.st = 1'b0; s.rs = 1'b0;
        return s;
    endfunction

    function automatic logic [18:0] obs_vec();
        return {ifc.rst_plu, ifc.eps_reg_we, ifc.we_prim, ifc.we_a_reg, ifc.mux_sel,
                ifc.start_plu, ifc.busy, ifc.done,
                ifc.converged, ifc.timeout, ifc.plu_err, ifc.iter_count};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // fr: round whose CHECK sees finish=1 (0 = never); l: WAIT cycles per round;
    // hang: plu_done never arrives; noisy: pulse start in WAIT and DONE; rst_cyc: cycle to assert rst (0 = none).
    task automatic run(input string name, input int fr, input int l, input bit hang,
                       input bit noisy, input int rst_cyc);
        step_t      tr[$];
        step_t      s;
        res_t       rr;
        logic [2:0] fin_fl;
        logic [7:0] fin_it;
        int         r;
        int         cyc;

        tr.push_back(mk(C_LOAD, 3'b000, 8'd0));
        if (hang) begin
            tr.push_back(mk(C_START, 3'b000, 8'd0));
            for (int w = 0; w < WAIT_LIMIT; w++) begin
                s = mk(C_WAIT, 3'b000, 8'd0);
                s.care_pd = 1'b1; s.st = noisy;
                tr.push_back(s);
            end
            fin_fl = 3'b001;
            fin_it = 8'd0;
        end else begin
            r = 0;
            forever begin
                r++;
                tr.push_back(mk(C_START, 3'b000, 8'(r - 1)));
                for (int w = 1; w <= l; w++) begin
                    s = mk(C_WAIT, 3'b000, 8'(r - 1));
                    s.care_pd = 1'b1; s.pd = (w == l); s.st = noisy;
                    tr.push_back(s);
                end
                tr.push_back(mk(C_UPD, 3'b000, 8'(r - 1)));
                s = mk(C_CHK, 3'b000, 8'(r));
                s.care_fn = 1'b1; s.fn = (r == fr);
                tr.push_back(s);
                if (r == fr || r == MAX_ITER) break;
            end
            fin_it = 8'(r);
            fin_fl = (r == fr) ? 3'b100 : 3'b010;
        end
        s = mk(C_DONE, fin_fl, fin_it);
        s.st = noisy;
        tr.push_back(s);
        tr.push_back(mk(C_IDLE, fin_fl, fin_it));

        if (rst_cyc > 0) begin
            while (tr.size() > rst_cyc) void'(tr.pop_back());
            tr[rst_cyc - 1].rs = 1'b1;
            tr.push_back(mk(C_IDLE, 3'b000, 8'd0));
        end else begin
            rr.fl = fin_fl;
            rr.it = fin_it;
            res_q.push_back(rr);
        end
        foreach (tr[i]) exp_q.push_back(tr[i]);

        ifc.start = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            cyc++;
            check($sformatf("%s_cyc%0d", name, cyc), 32'(obs_vec()), 32'({s.ctl, s.fl, s.it}));
            if (ifc.done === 1'b1) begin
                check($sformatf("%s_done_expected", name), 32'(res_q.size() > 0), 32'd1);
                if (res_q.size() > 0) begin
                    rr = res_q.pop_front();
                    check($sformatf("%s_result", name),
                          32'({ifc.converged, ifc.timeout, ifc.plu_err, ifc.iter_count}), 32'(rr));
                end
            end
            ifc.start    = s.st;
            ifc.plu_done = s.care_pd ? s.pd : 1'($urandom);
            ifc.finish   = s.care_fn ? s.fn : 1'($urandom);
            rst          = s.rs;
            @(negedge clk);
        end
        rst          = 1'b0;
        ifc.start    = 1'b0;
        ifc.plu_done = 1'b0;
        ifc.finish   = 1'b0;
    endtask

    initial begin
        ifc.start    = 1'b0;
        ifc.plu_done = 1'b0;
        ifc.finish   = 1'b0;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", 32'(obs_vec()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 32'(obs_vec()), 32'd0);

        run("converge",  2, 3, 1'b0, 1'b0, 0);
        run("iter_limit", 0, 3, 1'b0, 1'b0, 0);
        run("plu_hang",  0, 3, 1'b1, 1'b0, 0);
        run("priority",  4, 1, 1'b0, 1'b0, 0);
        run("ign_start", 2, 2, 1'b0, 1'b1, 0);
        run("hang_noisy", 0, 1, 1'b1, 1'b1, 0);
        run("rst_mid",   1, 3, 1'b0, 1'b0, 4);
        run("after_rst", 3, 2, 1'b0, 1'b0, 0);
        run("one_round", 1, 1, 1'b0, 1'b0, 0);

        check("results_drained", 32'(res_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maxnet_controller.md
# maxnet_controller

Sequencing FSM for the four-neuron Maxnet datapath. It drives the datapath control pins: init load, epsilon load, PLU reset/start, activation write-back and the init/feedback mux select. It then iterates PLU evaluation rounds until the output checker reports a single winner, or until an iteration limit is reached. It sits between the top-level start/done handshake and the datapath, one instance per datapath.

## Interface
Parameters:
- MAX_ITER, 16, maximum PLU rounds before forced stop; legal range 1..255.
- WAIT_LIMIT, 64, maximum cycles spent in WAIT per round before aborting; legal range 1..255.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request, sampled only in IDLE.
- plu_done  in  1  AND of the four PLU done flags.
- finish  in  1  output checker valid (single winner found).
- rst_plu  out  1  PLU reset.
- eps_reg_we  out  1  epsilon register write enable.
- we_prim  out  1  write enable for the initial-activation copy registers.
- we_a_reg  out  1  activation register write enable.
- mux_sel  out  1  0 selects init values, 1 selects PLU feedback.
- start_plu  out  1  PLU start pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- converged  out  1  sticky: run ended by finish.
- timeout  out  1  sticky: run ended by iteration limit.
- plu_err  out  1  sticky: run aborted by WAIT_LIMIT.
- iter_count  out  8  completed rounds in the current or last run.

## Operation
- States: IDLE, LOAD, START, WAIT, UPDATE, CHECK, DONE. All control outputs are Moore, decoded from state only.
- IDLE: all control outputs 0. If start=1, clear converged/timeout/plu_err/iter_count and go to LOAD. Otherwise stay in IDLE.
- LOAD (1 cycle): eps_reg_we=1, we_prim=1, we_a_reg=1, mux_sel=0, rst_plu=1. Go to START.
- START (1 cycle): start_plu=1. Clear the wait counter. Go to WAIT.
- WAIT: start_plu=0. The wait counter increments each cycle.
  - If plu_done=1, go to UPDATE.
  - Else, if the wait counter reaches WAIT_LIMIT, set plu_err and go to DONE.
- UPDATE (1 cycle): mux_sel=1, we_a_reg=1. iter_count increments. Go to CHECK.
- CHECK (1 cycle): rst_plu=1. Checks are evaluated in this order:
  - finish=1: set converged, go to DONE.
  - else iter_count==MAX_ITER: set timeout, go to DONE.
  - else go to START.
- finish has priority over the limit when both hold in the same CHECK cycle.
- DONE (1 cycle): done=1. Go to IDLE.
- Exactly one of converged/timeout/plu_err is set at the end of a run. Flags and iter_count hold until the next accepted start.
- start in any state other than IDLE is ignored. It is not queued.
- plu_done and finish are ignored outside WAIT and CHECK respectively.
- iter_count never exceeds MAX_ITER, so there is no wrap-around.

## Timing
- Reset (rst=1 at an edge) takes effect at that edge: state=IDLE, iter_count=0, wait counter=0, all outputs 0 including the sticky flags.
- Reset mid-run aborts with no done pulse. The next start performs a full LOAD.
- Numbering: cycle 1 is the first cycle after the edge that samples start=1 in IDLE.
  - Cycle 1 is LOAD.
  - Cycle 2 is START.
- Round length is L+3 cycles, where L is the number of WAIT cycles including the one with plu_done=1: START(1) + WAIT(L) + UPDATE(1) + CHECK(1).
- Total latency from start to done, for N rounds ending in CHECK: 1 + N·(L+3) + 1 cycles. done is high in the cycle after the final CHECK.
- A back-to-back run is possible. Earliest start acceptance is the IDLE cycle following DONE.

## Test plan
- **Convergence:** MAX_ITER=4, plu_done high on the 3rd WAIT cycle of each round, finish=1 during the 2nd CHECK.
  - Required: LOAD at cycle 1, start_plu at 2 and 8, we_a_reg at 1, 6 and 12, CHECK at 13, done at 14.
  - End state: converged=1, iter_count=2.
- **Iteration limit:** MAX_ITER=4, L=3, finish held 0.
  - Required: CHECKs at 7, 13, 19 and 25, done at 26.
  - End state: timeout=1, converged=0, iter_count=4.
- **PLU hang:** WAIT_LIMIT=5, plu_done held 0.
  - Required: WAIT on cycles 3–7, done at 8.
  - End state: plu_err=1, iter_count=0, no UPDATE write.
- **Priority:** finish=1 in a CHECK where iter_count==MAX_ITER.
  - Required: converged=1, timeout=0.
- **Reset mid-run:** rst=1 during the 2nd WAIT.
  - Required: next cycle busy=0, all outputs 0, no done pulse.
  - A following start gives LOAD at cycle 1.
- **Ignored start:** start pulsed during WAIT and during DONE.
  - Required: no state change and no restart.
  - The flags of the completed run remain readable until the next start accepted in IDLE.
